// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z output buffer: flag bundle, buffer state
// encoding and a small index-width helper.
package redmule_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } z_buffer_flgs_t;

  typedef enum logic [1:0] {
    ZBUF_EMPTY,
    ZBUF_FILL,
    ZBUF_DRAIN
  } zbuf_state_e;

  // Index width that stays at least one bit wide for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redmule_zbuf_mem.sv
// N_ELEM x DEPTH element array for the Z buffer. One full column is written
// per cycle and one full row is read out combinationally from the registers.
module redmule_zbuf_mem
  import redmule_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_ELEM = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned COL_W = idx_w(DEPTH),
  localparam int unsigned ROW_W = idx_w(N_ELEM)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      i_we,
  input  logic [COL_W-1:0]          i_col,
  input  logic [N_ELEM*DATA_W-1:0]  i_data,
  input  logic [ROW_W-1:0]          i_row,
  output logic [DEPTH*DATA_W-1:0]   o_row
);

  logic [DATA_W-1:0] r_mem [N_ELEM][DEPTH];

  // Column write port: element r of the incoming column lands in row r.
  // NOTE: this array is reset on purpose so the drained row reads as zero after
  // reset; a plain storage array would normally be left unreset to save flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N_ELEM; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      for (int r = 0; r < N_ELEM; r++) begin
        r_mem[r][i_col] <= i_data[r*DATA_W +: DATA_W];
      end
    end
  end

  // Row read port: gather every column of the selected row.
  // NOTE: o_row gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_row = '0;
    for (int c = 0; c < DEPTH; c++) begin
      o_row[c*DATA_W +: DATA_W] = r_mem[i_row][c];
    end
  end

endmodule

// File: rtl/redmule_zbuf_transpose.sv
// RedMulE Z output buffer: captures engine result columns (column-major),
// then drains row-major beats to the Z streamer over valid/ready.
// Optional feature macro: REDMULE_ZBUF_STRB_EN (byte strobes follow cols_i).
module redmule_zbuf_transpose
  import redmule_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_ELEM = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         clk_en_i,
  input  logic                         fill_i,
  input  logic [N_ELEM*DATA_W-1:0]     fill_data_i,
  input  logic [$clog2(N_ELEM):0]      rows_i,
  input  logic [$clog2(DEPTH):0]       cols_i,
  output logic [DEPTH*DATA_W-1:0]      z_data_o,
  output logic [DEPTH*DATA_W/8-1:0]    z_strb_o,
  output logic                         z_valid_o,
  input  logic                         z_ready_i,
  output z_buffer_flgs_t               flgs_o,
  output logic                         overflow_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned RCNT_W = $clog2(N_ELEM) + 1;
  localparam int unsigned COL_W  = idx_w(DEPTH);
  localparam int unsigned ROW_W  = idx_w(N_ELEM);

  zbuf_state_e       r_state;
  logic [CNT_W-1:0]  r_fill_cnt;
  logic [RCNT_W-1:0] r_drain_cnt;
  logic [RCNT_W-1:0] r_rows_eff;
  logic              r_full;
  logic              r_empty;
  logic              r_valid;
  logic              r_overflow;

  logic              w_fill_acc;
  logic              w_fill_last;
  logic              w_hs;
  logic              w_drain_last;
  logic [RCNT_W-1:0] w_rows_eff;

  assign w_fill_acc   = fill_i & clk_en_i & (r_state != ZBUF_DRAIN);
  assign w_fill_last  = w_fill_acc & (r_fill_cnt == CNT_W'(DEPTH - 1));
  assign w_hs         = r_valid & z_ready_i;
  assign w_drain_last = w_hs & (r_drain_cnt == r_rows_eff - RCNT_W'(1));
  assign w_rows_eff   = ((rows_i == '0) || (rows_i > RCNT_W'(N_ELEM))) ? RCNT_W'(N_ELEM) : rows_i;

  // Tile sequencing: accept columns until full, then hand out rows until the last beat.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ZBUF_EMPTY;
      r_fill_cnt  <= '0;
      r_drain_cnt <= '0;
      r_rows_eff  <= RCNT_W'(N_ELEM);
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ZBUF_EMPTY;
      r_fill_cnt  <= '0;
      r_drain_cnt <= '0;
      r_rows_eff  <= RCNT_W'(N_ELEM);
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (fill_i && (r_state == ZBUF_DRAIN)) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ZBUF_EMPTY, ZBUF_FILL: begin
          if (w_fill_acc) begin
            r_empty <= 1'b0;
            if (w_fill_last) begin
              r_state    <= ZBUF_DRAIN;
              r_fill_cnt <= '0;
              r_full     <= 1'b1;
              r_valid    <= 1'b1;
              r_rows_eff <= w_rows_eff;
            end else begin
              r_state    <= ZBUF_FILL;
              r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            end
          end
        end
        ZBUF_DRAIN: begin
          if (w_hs) begin
            if (w_drain_last) begin
              r_state     <= ZBUF_EMPTY;
              r_drain_cnt <= '0;
              r_full      <= 1'b0;
              r_empty     <= 1'b1;
              r_valid     <= 1'b0;
            end else begin
              r_drain_cnt <= r_drain_cnt + RCNT_W'(1);
            end
          end
        end
        default: r_state <= ZBUF_EMPTY;
      endcase
    end
  end

  // Storage is never written in the cycle a clear arrives.
  redmule_zbuf_mem #(
    .DATA_W (DATA_W),
    .N_ELEM (N_ELEM),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_we   (w_fill_acc & ~clear_i),
    .i_col  (r_fill_cnt[COL_W-1:0]),
    .i_data (fill_data_i),
    .i_row  (r_drain_cnt[ROW_W-1:0]),
    .o_row  (z_data_o)
  );

`ifdef REDMULE_ZBUF_STRB_EN
  logic [CNT_W-1:0] r_cols_eff;
  logic [CNT_W-1:0] w_cols_eff;

  assign w_cols_eff = ((cols_i == '0) || (cols_i > CNT_W'(DEPTH))) ? CNT_W'(DEPTH) : cols_i;

  // Column count for the tile, captured when the buffer turns full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cols_eff <= CNT_W'(DEPTH);
    end else if (clear_i) begin
      r_cols_eff <= CNT_W'(DEPTH);
    end else if (w_fill_last) begin
      r_cols_eff <= w_cols_eff;
    end
  end

  // Enable the bytes of every element that lies inside the valid column range.
  always_comb begin
    z_strb_o = '0;
    for (int c = 0; c < DEPTH; c++) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        z_strb_o[c*(DATA_W/8) + b] = (CNT_W'(c) < r_cols_eff);
      end
    end
  end
`else
  logic w_unused_cols;
  assign w_unused_cols = ^cols_i;
  assign z_strb_o      = '1;
`endif

  assign z_valid_o    = r_valid;
  assign flgs_o.full  = r_full;
  assign flgs_o.empty = r_empty;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_redmule_zbuf_transpose.sv
// Self-checking bench for redmule_zbuf_transpose (DATA_W=16, N_ELEM=4, DEPTH=8).
// The reference model is a plain 4x8 tile array: rows drain as the columns were
// filled, and only the first rows_eff rows ever appear on the Z stream.
module tb_redmule_zbuf_transpose;
  import redmule_pkg::*;

  localparam int DW = 16;
  localparam int NE = 4;
  localparam int DP = 8;

  logic              clk;
  logic              rst_ni;
  logic              clear_i;
  logic              clk_en_i;
  logic              fill_i;
  logic [NE*DW-1:0]  fill_data_i;
  logic [2:0]        rows_i;
  logic [3:0]        cols_i;
  logic [DP*DW-1:0]  z_data_o;
  logic [DP*DW/8-1:0] z_strb_o;
  logic              z_valid_o;
  logic              z_ready_i;
  z_buffer_flgs_t    flgs_o;
  logic              overflow_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [NE][DP];

  redmule_zbuf_transpose #(.DATA_W(DW), .N_ELEM(NE), .DEPTH(DP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .clk_en_i    (clk_en_i),
    .fill_i      (fill_i),
    .fill_data_i (fill_data_i),
    .rows_i      (rows_i),
    .cols_i      (cols_i),
    .z_data_o    (z_data_o),
    .z_strb_o    (z_strb_o),
    .z_valid_o   (z_valid_o),
    .z_ready_i   (z_ready_i),
    .flgs_o      (flgs_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < DP; c++) v[c*DW +: DW] = model[r][c];
    return v;
  endfunction

  function automatic logic [15:0] exp_strb(input int cols_eff);
    logic [15:0] s;
`ifdef REDMULE_ZBUF_STRB_EN
    s = '0;
    for (int c = 0; c < cols_eff; c++) s[2*c +: 2] = 2'b11;
`else
    s = 16'hFFFF;
    if (cols_eff < 0) s = '0;
`endif
    return s;
  endfunction

  // Push a full tile of 8 columns; pattern=1 uses element (r<<8)|c, else random.
  task automatic fill_tile(input bit pattern);
    logic [NE*DW-1:0] d;
    for (int c = 0; c < DP; c++) begin
      for (int r = 0; r < NE; r++) begin
        model[r][c] = pattern ? DW'((r << 8) | c) : DW'($urandom);
        d[r*DW +: DW] = model[r][c];
      end
      fill_i = 1'b1; clk_en_i = 1'b1; fill_data_i = d;
      tick();
      if (c < DP - 1) begin
        check("fill_flags", 128'(flgs_o), 128'(2'b00));
        check("fill_no_valid", 128'(z_valid_o), 128'(1'b0));
      end else begin
        check("full_flags", 128'(flgs_o), 128'(2'b10));
        check("full_valid", 128'(z_valid_o), 128'(1'b1));
      end
    end
    fill_i = 1'b0; fill_data_i = '0;
  endtask

  // Drain a tile. mode 0: always ready, 1: ready 1-0-0-1, 2: random ready.
  // inject=1 keeps fill_i high through the whole drain, last handshake included.
  task automatic drain_tile(input int rows_eff, input int cols_eff, input int mode, input bit inject);
    int beat;
    int cyc;
    bit rdy;
    beat = 0;
    cyc  = 0;
    while (beat < rows_eff && cyc < 200) begin
      check("beat_valid", 128'(z_valid_o), 128'(1'b1));
      check("beat_data", z_data_o, exp_row(beat));
      check("beat_strb", 128'(z_strb_o), 128'(exp_strb(cols_eff)));
      check("drain_flags", 128'(flgs_o), 128'(2'b10));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      z_ready_i = rdy;
      fill_i = inject; clk_en_i = 1'b1; fill_data_i = {$urandom, $urandom};
      tick();
      cyc++;
      if (rdy) beat++;
    end
    z_ready_i = 1'b0; fill_i = 1'b0; fill_data_i = '0;
    check("beat_count", 128'(beat), 128'(rows_eff));
    check("post_drain_valid", 128'(z_valid_o), 128'(1'b0));
    check("post_drain_flags", 128'(flgs_o), 128'(2'b01));
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; clk_en_i = 1'b0; fill_i = 1'b0;
    fill_data_i = '0; rows_i = '0; cols_i = '0; z_ready_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Reset state
    check("rst_flags", 128'(flgs_o), 128'(2'b01));
    check("rst_valid", 128'(z_valid_o), 128'(1'b0));
    check("rst_overflow", 128'(overflow_o), 128'(1'b0));
    check("rst_strb", 128'(z_strb_o), 128'(16'hFFFF));
    check("rst_data", z_data_o, 128'(0));

    // Directed pattern tile, rows_i/cols_i = 0 mean full tile
    rows_i = 3'd0; cols_i = 4'd0;
    fill_tile(1'b1);
    drain_tile(NE, DP, 0, 1'b0);

    // Random tile under 1-0-0-1 backpressure
    rows_i = 3'd4; cols_i = 4'd8;
    fill_tile(1'b0);
    drain_tile(NE, DP, 1, 1'b0);

    // Partial tile: 2 rows, 3 columns
    rows_i = 3'd2; cols_i = 4'd3;
    fill_tile(1'b0);
    drain_tile(2, 3, 0, 1'b0);

    // Random partial tiles with random backpressure
    for (int i = 0; i < 3; i++) begin
      int re;
      int ce;
      re = int'($urandom_range(1, NE));
      ce = int'($urandom_range(1, DP));
      rows_i = 3'(re); cols_i = 4'(ce);
      fill_tile(1'b0);
      drain_tile(re, ce, 2, 1'b0);
    end
    check("no_overflow_yet", 128'(overflow_o), 128'(1'b0));

    // Illegal fills during DRAIN and at the last handshake
    rows_i = 3'd4; cols_i = 4'd8;
    fill_tile(1'b0);
    drain_tile(NE, DP, 2, 1'b1);
    check("overflow_set", 128'(overflow_o), 128'(1'b1));
    tick(); tick();
    check("overflow_sticky", 128'(overflow_o), 128'(1'b1));
    check("idle_after_ovf", 128'(flgs_o), 128'(2'b01));
    fill_tile(1'b0);
    drain_tile(NE, DP, 0, 1'b0);
    check("overflow_still", 128'(overflow_o), 128'(1'b1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("overflow_cleared", 128'(overflow_o), 128'(1'b0));

    // Gated fills are ignored without raising overflow
    for (int i = 0; i < 5; i++) begin
      fill_i = 1'b1; clk_en_i = 1'b0; fill_data_i = {$urandom, $urandom};
      tick();
      check("gate_flags", 128'(flgs_o), 128'(2'b01));
      check("gate_overflow", 128'(overflow_o), 128'(1'b0));
    end
    fill_i = 1'b0; clk_en_i = 1'b1;
    fill_tile(1'b0);
    drain_tile(NE, DP, 0, 1'b0);

    // Clear at fill_cnt=5 wins over a simultaneous fill
    for (int c = 0; c < 5; c++) begin
      fill_i = 1'b1; clk_en_i = 1'b1; fill_data_i = {$urandom, $urandom};
      tick();
      check("part_fill_flags", 128'(flgs_o), 128'(2'b00));
    end
    clear_i = 1'b1; fill_i = 1'b1;
    tick();
    clear_i = 1'b0; fill_i = 1'b0;
    check("clear_flags", 128'(flgs_o), 128'(2'b01));
    check("clear_valid", 128'(z_valid_o), 128'(1'b0));
    fill_tile(1'b0);
    drain_tile(NE, DP, 0, 1'b0);

    // Asynchronous reset in the middle of DRAIN
    fill_tile(1'b0);
    z_ready_i = 1'b1;
    tick();
    z_ready_i = 1'b0;
    check("pre_rst_row1", z_data_o, exp_row(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 128'(z_valid_o), 128'(1'b0));
    check("arst_flags", 128'(flgs_o), 128'(2'b01));
    check("arst_data", z_data_o, 128'(0));
    check("arst_strb", 128'(z_strb_o), 128'(16'hFFFF));
    tick();
    rst_ni = 1'b1;
    tick();
    fill_tile(1'b1);
    drain_tile(NE, DP, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
